// File: rtl/xfifo_pkg.sv
// Shared sizing helpers for the level-tracking FIFO family.
package xfifo_pkg;

    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/xfifo_lvl_ctrl.sv
// FIFO control: accept logic, wrapping pointers, occupancy level and registered flags.
// With XFIFO_LVL_ERR_EN defined, sticky overflow/underflow indicators are added.
module xfifo_lvl_ctrl
    import xfifo_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int AFULL_LVL     = DEPTH - 1,
    parameter int AEMPTY_LVL    = 1,
    parameter int WR_ON_FULL_RD = 0,
    localparam int LW           = lvl_w(DEPTH),
    localparam int AW           = ptr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic          re_i,
    output logic          we_ok_o,
    output logic [AW-1:0] wptr_o,
    output logic [AW-1:0] rptr_o,
    output logic          full_n_o,
    output logic          empty_n_o,
    output logic          afull_n_o,
    output logic          aempty_n_o,
    output logic [LW-1:0] level_o
`ifdef XFIFO_LVL_ERR_EN
    ,
    output logic          err_ovf_o,
    output logic          err_udf_o
`endif
);

    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          full_n_q, empty_n_q, afull_n_q, aempty_n_q;
    logic          re_ok, we_ok;

    assign re_ok = re_i & empty_n_q;
    // A full FIFO can still take a write when the head leaves in the same cycle.
    assign we_ok = we_i & (full_n_q | ((WR_ON_FULL_RD != 0) && re_ok));

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q + {{(LW-1){1'b0}}, we_ok} - {{(LW-1){1'b0}}, re_ok};
        if (we_ok) begin
            wptr_d = (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + AW'(1);
        end
        if (re_ok) begin
            rptr_d = (rptr_q == AW'(DEPTH - 1)) ? '0 : rptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            full_n_q   <= 1'b1;
            empty_n_q  <= 1'b0;
            afull_n_q  <= 1'b1;
            aempty_n_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            full_n_q   <= (level_d != LW'(DEPTH));
            empty_n_q  <= (level_d != '0);
            afull_n_q  <= (level_d < LW'(AFULL_LVL));
            aempty_n_q <= (level_d > LW'(AEMPTY_LVL));
        end
    end

    // Storage must not see a write that reset is discarding.
    assign we_ok_o    = we_ok & ~rst;
    assign wptr_o     = wptr_q;
    assign rptr_o     = rptr_q;
    assign full_n_o   = full_n_q;
    assign empty_n_o  = empty_n_q;
    assign afull_n_o  = afull_n_q;
    assign aempty_n_o = aempty_n_q;
    assign level_o    = level_q;

`ifdef XFIFO_LVL_ERR_EN
    logic err_ovf_q, err_ovf_d, err_udf_q, err_udf_d;

    assign err_ovf_d = err_ovf_q | (we_i & ~we_ok);
    assign err_udf_d = err_udf_q | (re_i & ~empty_n_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            err_ovf_q <= err_ovf_d;
            err_udf_q <= err_udf_d;
        end
    end

    assign err_ovf_o = err_ovf_q;
    assign err_udf_o = err_udf_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(we_i && !we_ok)) else $warning("xfifo_lvl: write rejected while full");
            assert (!(re_i && !empty_n_q)) else $warning("xfifo_lvl: read requested while empty");
        end
    end
`endif
`endif

endmodule

// File: rtl/xfifo_lvl_mem.sv
// Two-port storage array: synchronous write, combinational (show-ahead) read.
module xfifo_lvl_mem
    import xfifo_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    localparam int AW   = ptr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/xfifo_lvl.sv
// Synchronous FIFO with any DEPTH >= 2, registered level and almost-full/empty flags.
// Optional sticky error outputs err_ovf/err_udf when XFIFO_LVL_ERR_EN is defined.
module xfifo_lvl
    import xfifo_pkg::*;
#(
    parameter int DW            = 8,
    parameter int DEPTH         = 4,
    parameter int AFULL_LVL     = DEPTH - 1,
    parameter int AEMPTY_LVL    = 1,
    parameter int WR_ON_FULL_RD = 0,
    localparam int LW           = lvl_w(DEPTH),
    localparam int AW           = ptr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          re,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q,
    output logic          full_n,
    output logic          empty_n,
    output logic          afull_n,
    output logic          aempty_n,
    output logic [LW-1:0] level
`ifdef XFIFO_LVL_ERR_EN
    ,
    output logic          err_ovf,
    output logic          err_udf
`endif
);

    logic          we_ok;
    logic [AW-1:0] wptr, rptr;

    xfifo_lvl_ctrl #(
        .DEPTH        (DEPTH),
        .AFULL_LVL    (AFULL_LVL),
        .AEMPTY_LVL   (AEMPTY_LVL),
        .WR_ON_FULL_RD(WR_ON_FULL_RD)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .we_i      (we),
        .re_i      (re),
        .we_ok_o   (we_ok),
        .wptr_o    (wptr),
        .rptr_o    (rptr),
        .full_n_o  (full_n),
        .empty_n_o (empty_n),
        .afull_n_o (afull_n),
        .aempty_n_o(aempty_n),
        .level_o   (level)
`ifdef XFIFO_LVL_ERR_EN
        ,
        .err_ovf_o (err_ovf),
        .err_udf_o (err_udf)
`endif
    );

    xfifo_lvl_mem #(
        .DW   (DW),
        .DEPTH(DEPTH)
    ) u_mem (
        .clk    (clk),
        .we_i   (we_ok),
        .waddr_i(wptr),
        .wdata_i(d),
        .raddr_i(rptr),
        .rdata_o(q)
    );

`ifndef SYNTHESIS
    initial begin
        if (DEPTH < 2) $error("xfifo_lvl: DEPTH must be >= 2");
        if (AFULL_LVL < 1 || AFULL_LVL > DEPTH) $error("xfifo_lvl: AFULL_LVL out of 1..DEPTH");
        if (AEMPTY_LVL >= AFULL_LVL) $error("xfifo_lvl: AEMPTY_LVL must be below AFULL_LVL");
    end
`endif

endmodule

// File: tb/tb_xfifo_lvl.sv
// Directed bench: instance 0 DEPTH=5, instance 1 DEPTH=6 AFULL=4 AEMPTY=1,
// instance 2 DEPTH=5 with write-through-when-full.
module tb_xfifo_lvl;

    logic       clk = 1'b0;
    logic       rst;
    logic       we_v [3];
    logic       re_v [3];
    logic [7:0] d_v  [3];
    logic [7:0] q_v  [3];
    logic       full_v [3];
    logic       empty_v [3];
    logic       afull_v [3];
    logic       aempty_v [3];
    logic [2:0] lvl_v [3];
`ifdef XFIFO_LVL_ERR_EN
    logic       eo_v [3];
    logic       eu_v [3];
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    xfifo_lvl #(.DW(8), .DEPTH(5)) u_a (
        .clk(clk), .rst(rst), .we(we_v[0]), .re(re_v[0]), .d(d_v[0]), .q(q_v[0]),
        .full_n(full_v[0]), .empty_n(empty_v[0]), .afull_n(afull_v[0]),
        .aempty_n(aempty_v[0]), .level(lvl_v[0])
`ifdef XFIFO_LVL_ERR_EN
        , .err_ovf(eo_v[0]), .err_udf(eu_v[0])
`endif
    );

    xfifo_lvl #(.DW(8), .DEPTH(6), .AFULL_LVL(4), .AEMPTY_LVL(1)) u_b (
        .clk(clk), .rst(rst), .we(we_v[1]), .re(re_v[1]), .d(d_v[1]), .q(q_v[1]),
        .full_n(full_v[1]), .empty_n(empty_v[1]), .afull_n(afull_v[1]),
        .aempty_n(aempty_v[1]), .level(lvl_v[1])
`ifdef XFIFO_LVL_ERR_EN
        , .err_ovf(eo_v[1]), .err_udf(eu_v[1])
`endif
    );

    xfifo_lvl #(.DW(8), .DEPTH(5), .WR_ON_FULL_RD(1)) u_c (
        .clk(clk), .rst(rst), .we(we_v[2]), .re(re_v[2]), .d(d_v[2]), .q(q_v[2]),
        .full_n(full_v[2]), .empty_n(empty_v[2]), .afull_n(afull_v[2]),
        .aempty_n(aempty_v[2]), .level(lvl_v[2])
`ifdef XFIFO_LVL_ERR_EN
        , .err_ovf(eo_v[2]), .err_udf(eu_v[2])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int k, input logic [7:0] v);
        we_v[k] = 1'b1;
        d_v[k]  = v;
        step();
        we_v[k] = 1'b0;
    endtask

    task automatic pop_chk(input int k, input logic [7:0] exp, input string tag);
        chk(tag, 32'(q_v[k]), 32'(exp));
        re_v[k] = 1'b1;
        step();
        re_v[k] = 1'b0;
    endtask

    // Expected flags indexed by level 0..6 for instance 1.
    logic [6:0] af_tab = 7'b000_1111;
    logic [6:0] ae_tab = 7'b111_1100;

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            we_v[k] = 1'b0;
            re_v[k] = 1'b0;
            d_v[k]  = 8'h00;
        end
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_level",    32'(lvl_v[0]),    32'd0);
        chk("rst_empty_n",  32'(empty_v[0]),  32'd0);
        chk("rst_full_n",   32'(full_v[0]),   32'd1);
        chk("rst_aempty_n", 32'(aempty_v[0]), 32'd0);
        chk("rst_afull_n",  32'(afull_v[0]),  32'd1);

        // Fill DEPTH=5, overfill, drain
        for (int i = 0; i < 5; i++) begin
            push(0, 8'(8'h11 + i));
            if (i == 0) begin
                chk("fill_q_first",   32'(q_v[0]),     32'h11);
                chk("fill_empty_n_1", 32'(empty_v[0]), 32'd1);
            end
        end
        chk("fill_level",    32'(lvl_v[0]),    32'd5);
        chk("fill_full_n",   32'(full_v[0]),   32'd0);
        chk("fill_afull_n",  32'(afull_v[0]),  32'd0);
        chk("fill_aempty_n", 32'(aempty_v[0]), 32'd1);
        push(0, 8'h99);
        chk("ovf_level", 32'(lvl_v[0]), 32'd5);
        chk("ovf_q",     32'(q_v[0]),   32'h11);
        for (int i = 0; i < 5; i++) begin
            pop_chk(0, 8'(8'h11 + i), "drain_q");
            if (i == 0) begin
                chk("drain_full_n_rise", 32'(full_v[0]), 32'd1);
                chk("drain_level_4",     32'(lvl_v[0]),  32'd4);
            end
        end
        chk("drain_empty_n",  32'(empty_v[0]),  32'd0);
        chk("drain_level",    32'(lvl_v[0]),    32'd0);
        chk("drain_aempty_n", 32'(aempty_v[0]), 32'd0);
        re_v[0] = 1'b1;
        step();
        re_v[0] = 1'b0;
        chk("udf_level",   32'(lvl_v[0]),   32'd0);
        chk("udf_empty_n", 32'(empty_v[0]), 32'd0);
        push(0, 8'h22);
        chk("udf_after_q", 32'(q_v[0]), 32'h22);
        pop_chk(0, 8'h22, "udf_after_pop");

        // Alternating write/read pairs wrap pointers twice
        for (int i = 0; i < 12; i++) begin
            push(0, 8'(8'h30 + i));
            chk("alt_level_1", 32'(lvl_v[0]), 32'd1);
            pop_chk(0, 8'(8'h30 + i), "alt_q");
            chk("alt_level_0", 32'(lvl_v[0]), 32'd0);
        end

        // Almost-full / almost-empty on DEPTH=6, AFULL=4, AEMPTY=1
        for (int l = 1; l <= 6; l++) begin
            push(1, 8'(8'h70 + l));
            chk("af_up_level",  32'(lvl_v[1]),    32'(l));
            chk("af_up_afull",  32'(afull_v[1]),  32'(af_tab[l]));
            chk("af_up_aempty", 32'(aempty_v[1]), 32'(ae_tab[l]));
        end
        chk("b_full_n", 32'(full_v[1]), 32'd0);
        for (int l = 5; l >= 0; l--) begin
            pop_chk(1, 8'(8'h70 + 6 - l), "af_dn_q");
            chk("af_dn_level",  32'(lvl_v[1]),    32'(l));
            chk("af_dn_afull",  32'(afull_v[1]),  32'(af_tab[l]));
            chk("af_dn_aempty", 32'(aempty_v[1]), 32'(ae_tab[l]));
        end

        // Full with simultaneous write and read, WR_ON_FULL_RD=0
        for (int i = 0; i < 5; i++) push(0, 8'(8'h41 + i));
        we_v[0] = 1'b1; re_v[0] = 1'b1; d_v[0] = 8'h46;
        step();
        we_v[0] = 1'b0; re_v[0] = 1'b0;
        chk("wfr0_level",  32'(lvl_v[0]),  32'd4);
        chk("wfr0_full_n", 32'(full_v[0]), 32'd1);
        for (int i = 0; i < 4; i++) pop_chk(0, 8'(8'h42 + i), "wfr0_q");
        chk("wfr0_empty_n", 32'(empty_v[0]), 32'd0);

        // Full with simultaneous write and read, WR_ON_FULL_RD=1
        for (int i = 0; i < 5; i++) push(2, 8'(8'h51 + i));
        we_v[2] = 1'b1; re_v[2] = 1'b1; d_v[2] = 8'h56;
        step();
        we_v[2] = 1'b0; re_v[2] = 1'b0;
        chk("wfr1_level",  32'(lvl_v[2]),  32'd5);
        chk("wfr1_full_n", 32'(full_v[2]), 32'd0);
        for (int i = 0; i < 5; i++) pop_chk(2, 8'(8'h52 + i), "wfr1_q");
        chk("wfr1_empty_n", 32'(empty_v[2]), 32'd0);

        // Reset mid-operation with a concurrent write
        for (int i = 0; i < 3; i++) push(0, 8'(8'h61 + i));
        chk("mid_level_3", 32'(lvl_v[0]), 32'd3);
        rst = 1'b1; we_v[0] = 1'b1; d_v[0] = 8'h77;
        step();
        rst = 1'b0; we_v[0] = 1'b0;
        chk("mid_rst_level",   32'(lvl_v[0]),   32'd0);
        chk("mid_rst_empty_n", 32'(empty_v[0]), 32'd0);
        chk("mid_rst_full_n",  32'(full_v[0]),  32'd1);
        push(0, 8'hA5);
        chk("mid_rst_level_1", 32'(lvl_v[0]), 32'd1);
        pop_chk(0, 8'hA5, "mid_rst_q");
        chk("mid_rst_empty_2", 32'(empty_v[0]), 32'd0);

`ifdef XFIFO_LVL_ERR_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("err_rst_ovf", 32'(eo_v[0]), 32'd0);
        chk("err_rst_udf", 32'(eu_v[0]), 32'd0);
        for (int i = 0; i < 5; i++) push(0, 8'(8'h81 + i));
        chk("err_ovf_pre", 32'(eo_v[0]), 32'd0);
        push(0, 8'h8F);
        chk("err_ovf_set", 32'(eo_v[0]), 32'd1);
        for (int i = 0; i < 5; i++) pop_chk(0, 8'(8'h81 + i), "err_drain_q");
        chk("err_ovf_sticky", 32'(eo_v[0]), 32'd1);
        chk("err_udf_pre",    32'(eu_v[0]), 32'd0);
        re_v[0] = 1'b1;
        step();
        re_v[0] = 1'b0;
        chk("err_udf_set", 32'(eu_v[0]), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("err_clr_ovf", 32'(eo_v[0]), 32'd0);
        chk("err_clr_udf", 32'(eu_v[0]), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
